// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA opcodes, bubble instruction and fetch FSM encoding
// Ports: none (package); imported by the fetch stage
package cpu_isa_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b101010;
  localparam logic [5:0] OP_VBNZ = 6'b100010;
  localparam logic [5:0] OP_VBENZ = 6'b100011;
  localparam logic [5:0] OP_LD = 6'b100000;
  localparam logic [5:0] OP_SD = 6'b100001;
  localparam logic [5:0] OP_NOP = 6'b111100;
  localparam logic [31:0] NOP_WORD = {OP_NOP, 26'd0};
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIRECT, S_RESET_HOLD} fetch_state_e;
  function automatic logic [15:0] align_target(input logic [15:0] t);
    return {t[15:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: hazard/branch controls, imem read port and IF/ID outputs
// master (fetch stage): in stall, branch_taken, branch_target, imem_rdata;
//   out imem_en, imem_addr, if_id_instr, if_id_pc, if_id_valid
// slave (environment): the mirror image
interface instr_fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32
);
  logic stall;
  logic branch_taken;
  logic [15:0] branch_target;
  logic imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic if_id_valid;
  modport master (
    input stall, branch_taken, branch_target, imem_rdata,
    output imem_en, imem_addr, if_id_instr, if_id_pc, if_id_valid
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input imem_en, imem_addr, if_id_instr, if_id_pc, if_id_valid
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 1-entry {instr, pc} holding register for words returning during a stall
// Ports: clk, reset_n (sync, active-low); i_load/i_pop/i_clear controls (clear > load > pop);
//   i_instr/i_pc entry data; o_valid/o_instr/o_pc held entry
module fetch_skid_buffer #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_pop,
  input  logic i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc
);
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_instr <= i_instr;
      o_pc <= i_pc;
    end else if (i_pop) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, synchronous imem fetch, stall skid and IF/ID register with branch squash
// Ports: clk; reset_n (sync, active-low); bus (instr_fetch_stage_if.master)
// Optional FETCH_PERF_CNT_EN: adds saturating perf_fetched, perf_bubbles, perf_stall_cyc outputs
module instr_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD = cpu_isa_pkg::NOP_WORD
) (
  input logic clk,
  input logic reset_n,
  instr_fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_stall_cyc
`endif
);
  import cpu_isa_pkg::*;
  fetch_state_e r_state, w_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, r_inflight_pc, r_if_pc, w_target, w_ld_pc, w_skid_pc;
  logic [INSTR_W-1:0] r_instr, w_ld_instr, w_skid_instr;
  logic r_inflight, r_valid, w_go, w_issue, w_ld_valid, w_skid_valid, w_skid_load;
  // While reset_n is low the FSM decodes as S_RESET_HOLD so no fetch can escape
  always_comb begin
    w_state = reset_n ? r_state : S_RESET_HOLD;
    w_go = !bus.stall && !bus.branch_taken;
    w_issue = reset_n && (w_state != S_RESET_HOLD) && w_go;
    w_next_state = bus.branch_taken ? S_REDIRECT : w_issue ? S_RUN : r_state;
    w_target = ADDR_W'(align_target(bus.branch_target));
    w_skid_load = bus.stall && !bus.branch_taken && r_inflight;
    w_ld_valid = w_skid_valid || r_inflight;
    w_ld_instr = w_skid_valid ? w_skid_instr : r_inflight ? bus.imem_rdata : NOP_WORD;
    w_ld_pc = w_skid_valid ? w_skid_pc : r_inflight ? r_inflight_pc : r_if_pc;
  end
  fetch_skid_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
    .clk(clk),
    .reset_n(reset_n),
    .i_load(w_skid_load),
    .i_pop(w_go),
    .i_clear(bus.branch_taken),
    .i_instr(bus.imem_rdata),
    .i_pc(r_inflight_pc),
    .o_valid(w_skid_valid),
    .o_instr(w_skid_instr),
    .o_pc(w_skid_pc)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_BOOT;
      r_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_inflight_pc <= '0;
      r_instr <= NOP_WORD;
      r_if_pc <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc <= bus.branch_taken ? w_target : w_issue ? r_pc + ADDR_W'(4) : r_pc;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      if (bus.branch_taken) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (!bus.stall) begin
        r_instr <= w_ld_instr;
        r_if_pc <= w_ld_pc;
        r_valid <= w_ld_valid;
      end
    end
  end
  assign bus.imem_en = w_issue;
  assign bus.imem_addr = r_pc;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_pc = r_if_pc;
  assign bus.if_id_valid = r_valid;
  // No fetch is issued while stalled, so a full skid never coexists with an outstanding read
  a_skid_depth: assert property (@(posedge clk) disable iff (!reset_n) !(w_skid_valid && r_inflight));
`ifdef FETCH_PERF_CNT_EN
  logic w_if_load, w_if_valid;
  always_comb begin
    w_if_load = bus.branch_taken || !bus.stall;
    w_if_valid = !bus.branch_taken && w_ld_valid;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (w_if_load && w_if_valid && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (w_if_load && !w_if_valid && !(&perf_bubbles)) perf_bubbles <= perf_bubbles + 32'd1;
      if (bus.stall && !(&perf_stall_cyc)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: scoreboard bench for instr_fetch_stage against an in-order stream model
module tb_instr_fetch_stage;
  localparam logic [31:0] NOP = 32'hF000_0000;
  typedef struct {
    bit valid;
    logic [31:0] instr;
    logic [31:0] pc;
    bit pcchk;
    logic [31:0] addr;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  logic rst2;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  exp_t cur;
  bit primed;
  logic [31:0] nxt;
  int cnt_f, cnt_b, cnt_s;
  always #5 clk = ~clk;
  instr_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
  instr_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus2 ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_stall_cyc, w_pf, w_pb, w_ps;
`endif
  instr_fetch_stage u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles), .perf_stall_cyc(perf_stall_cyc)
`endif
  );
  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk),
    .reset_n(rst2),
    .bus(bus2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_pf), .perf_bubbles(w_pb), .perf_stall_cyc(w_ps)
`endif
  );
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction
  // Synchronous imem: data one cycle after enable, garbage otherwise
  always @(posedge clk) bus.imem_rdata <= bus.imem_en ? memf(bus.imem_addr) : $urandom;
  always @(posedge clk) bus2.imem_rdata <= bus2.imem_en ? memf(bus2.imem_addr) : $urandom;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: after reset or a redirect the first unstalled edge only primes the fetch;
  // every later unstalled edge delivers the next in-order word; stalls hold IF/ID.
  task automatic step(input bit rn, input bit st, input bit br, input logic [15:0] tg);
    @(negedge clk);
    reset_n = rn;
    bus.stall = st;
    bus.branch_taken = br;
    bus.branch_target = tg;
    if (!rn) begin
      primed = 0;
      nxt = '0;
      cur.valid = 0; cur.instr = NOP; cur.pc = '0; cur.pcchk = 1;
      cnt_f = 0; cnt_b = 0; cnt_s = 0;
    end else if (br) begin
      primed = 0;
      nxt = {16'd0, tg[15:2], 2'b00};
      cur.valid = 0; cur.instr = NOP; cur.pcchk = 0;
      cnt_b++;
      if (st) cnt_s++;
    end else if (st) begin
      cnt_s++;
    end else if (!primed) begin
      primed = 1;
      cur.valid = 0; cur.instr = NOP; cur.pcchk = 0;
      cnt_b++;
    end else begin
      cur.valid = 1; cur.instr = memf(nxt); cur.pc = nxt; cur.pcchk = 1;
      nxt = nxt + 32'd4;
      cnt_f++;
    end
    cur.addr = primed ? nxt + 32'd4 : nxt;
    q.push_back(cur);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("imem_en", 32'(bus.imem_en), 32'(reset_n && !bus.stall && !bus.branch_taken));
      if (q.size() > 0) begin
        e = q.pop_front();
        check("if_id_valid", 32'(bus.if_id_valid), 32'(e.valid));
        check("if_id_instr", bus.if_id_instr, e.instr);
        if (e.pcchk) check("if_id_pc", bus.if_id_pc, e.pc);
        check("imem_addr", bus.imem_addr, e.addr);
      end
    end
  end
  initial begin
    int k;
    reset_n = 1'b0;
    rst2 = 1'b0;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus2.stall = 0; bus2.branch_taken = 0; bus2.branch_target = '0;
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 1, 16'h0040);
    repeat (4) step(1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 16'h0100);
    repeat (4) step(1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 1, 16'h0043);
    repeat (3) step(1, 0, 0, 0);
    repeat (1500) step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) == 0, 16'($urandom));
    repeat (4) step(1, 0, 0, 0);
    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, cnt_f);
    check("perf_bubbles", perf_bubbles, cnt_b);
    check("perf_stall_cyc", perf_stall_cyc, cnt_s);
`endif
    @(negedge clk);
    rst2 = 1'b1;
    k = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus2.if_id_valid && k < 5) begin
        check("wrap_pc", bus2.if_id_pc, 32'hFFFF_FFF8 + 32'(4 * k));
        check("wrap_instr", bus2.if_id_instr, memf(32'hFFFF_FFF8 + 32'(4 * k)));
        k++;
      end
    end
    check("wrap_count", k, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
